conv_pool_sequencer: RTL and testbench

//  Parametrised layer controller for the 1-D CNN ECG pipeline.
//  - Streams CH-lane input samples into a K-tap sliding window per lane, appending PAD zero samples at the tail.
//  - Hands the window to an external conv datapath, applies ReLU to each result, and max-pools POOL results per lane.
//  - Emits pooled vectors with a valid/ready handshake.
//  - One instance per conv/ReLU/maxpool layer, between the previous layer's output stream and the next layer's input.

---
 rtl/conv_pool_sequencer_if.sv | 28 ++
 rtl/conv_pool_sequencer.sv | 173 +++++++++++++++++
 tb/tb_conv_pool_sequencer.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_pool_sequencer_if.sv
// Stream, window and result signals between a conv/ReLU/maxpool layer sequencer
// and its neighbours (previous layer, conv datapath, next layer).
interface conv_pool_sequencer_if #(
    parameter int unsigned CH = 8,
    parameter int unsigned DW = 8,
    parameter int unsigned K  = 5
);
    logic                 in_valid;
    logic                 in_ready;
    logic [CH*DW-1:0]     in_data;
    logic [CH*K*DW-1:0]   win_data;
    logic                 conv_start;
    logic                 conv_valid;
    logic [CH*DW-1:0]     conv_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [CH*DW-1:0]     out_data;

    modport master (
        input  in_valid, in_data, conv_valid, conv_data, out_ready,
        output in_ready, win_data, conv_start, out_valid, out_data
    );

    modport slave (
        output in_valid, in_data, conv_valid, conv_data, out_ready,
        input  in_ready, win_data, conv_start, out_valid, out_data
    );
endinterface

// File: rtl/conv_pool_sequencer.sv
// Layer controller: per-lane K-tap sliding window with tail padding, handoff to an
// external conv datapath, ReLU, POOL-wide max-pooling and a valid/ready result stream.
module conv_pool_sequencer #(
    parameter int unsigned CH     = 8,
    parameter int unsigned DW     = 8,
    parameter int unsigned K      = 5,
    parameter int unsigned POOL   = 5,
    parameter int unsigned IN_LEN = 100,
    parameter int unsigned PAD    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    conv_pool_sequencer_if.master bus
);
    localparam int unsigned N_CONV = IN_LEN + PAD - K + 1;
    localparam int unsigned SW     = $clog2(IN_LEN + PAD + 1);
    localparam int unsigned PW     = $clog2(POOL + 1);
    localparam int unsigned CW     = $clog2(N_CONV + 1);
    localparam int unsigned VW     = CH * DW;
    localparam int unsigned WW     = CH * K * DW;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CONV, S_EMIT, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   shifts_q, shifts_d, shifts_inc;
    logic [PW-1:0]   pcnt_q, pcnt_d, pcnt_inc;
    logic [CW-1:0]   ncv_q, ncv_d, ncv_inc;
    logic [WW-1:0]   win_q, win_d, win_shift;
    logic [VW-1:0]   pool_q, pool_d, pool_upd;
    logic [VW-1:0]   out_data_q, out_data_d;
    logic            in_ready_q, in_ready_d;
    logic            conv_start_q, conv_start_d;
    logic            out_valid_q, out_valid_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            feed_real, shift_en;
    logic signed [DW-1:0] lane_res, lane_relu, lane_pool;

    assign shifts_inc = shifts_q + SW'(1);
    assign pcnt_inc   = pcnt_q + PW'(1);
    assign ncv_inc    = ncv_q + CW'(1);
    assign feed_real  = shifts_q < SW'(IN_LEN);

    // Each lane's taps age by one; tap 0 takes the new sample, or zero once padding.
    always_comb begin
        win_shift = '0;
        for (int unsigned c = 0; c < CH; c++) begin
            for (int unsigned t = 1; t < K; t++) begin
                win_shift[(c*K+t)*DW +: DW] = win_q[(c*K+t-1)*DW +: DW];
            end
            win_shift[c*K*DW +: DW] = feed_real ? bus.in_data[c*DW +: DW] : '0;
        end
    end

    // ReLU the conv result and fold it into the running per-lane maximum.
    always_comb begin
        pool_upd  = '0;
        lane_res  = '0;
        lane_relu = '0;
        lane_pool = '0;
        for (int unsigned c = 0; c < CH; c++) begin
            lane_res  = $signed(bus.conv_data[c*DW +: DW]);
            lane_relu = lane_res[DW-1] ? '0 : lane_res;
            lane_pool = $signed(pool_q[c*DW +: DW]);
            pool_upd[c*DW +: DW] = (pcnt_q == '0 || lane_relu > lane_pool) ? lane_relu : lane_pool;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            shifts_q     <= '0;
            pcnt_q       <= '0;
            ncv_q        <= '0;
            win_q        <= '0;
            pool_q       <= '0;
            out_data_q   <= '0;
            in_ready_q   <= 1'b0;
            conv_start_q <= 1'b0;
            out_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            shifts_q     <= shifts_d;
            pcnt_q       <= pcnt_d;
            ncv_q        <= ncv_d;
            win_q        <= win_d;
            pool_q       <= pool_d;
            out_data_q   <= out_data_d;
            in_ready_q   <= in_ready_d;
            conv_start_q <= conv_start_d;
            out_valid_q  <= out_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        shifts_d     = shifts_q;
        pcnt_d       = pcnt_q;
        ncv_d        = ncv_q;
        win_d        = win_q;
        pool_d       = pool_q;
        out_data_d   = out_data_q;
        out_valid_d  = out_valid_q;
        conv_start_d = 1'b0;
        shift_en     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_LOAD;
                    win_d    = '0;
                    shifts_d = '0;
                    pcnt_d   = '0;
                    ncv_d    = '0;
                    pool_d   = '0;
                end
            end
            S_LOAD: begin
                shift_en = feed_real ? (bus.in_valid && in_ready_q) : 1'b1;
                if (shift_en) begin
                    win_d    = win_shift;
                    shifts_d = shifts_inc;
                    if (shifts_inc >= SW'(K)) begin
                        state_d      = S_CONV;
                        conv_start_d = 1'b1;
                    end
                end
            end
            S_CONV: begin
                if (bus.conv_valid) begin
                    pool_d = pool_upd;
                    ncv_d  = ncv_inc;
                    if (pcnt_inc == PW'(POOL)) begin
                        pcnt_d      = '0;
                        out_data_d  = pool_upd;
                        out_valid_d = 1'b1;
                        state_d     = S_EMIT;
                    end else begin
                        pcnt_d  = pcnt_inc;
                        state_d = (ncv_inc == CW'(N_CONV)) ? S_DONE : S_LOAD;
                    end
                end
            end
            S_EMIT: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = (ncv_q == CW'(N_CONV)) ? S_DONE : S_LOAD;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        in_ready_d = (state_d == S_LOAD) && (shifts_d < SW'(IN_LEN));
        busy_d     = state_d != S_IDLE;
        done_d     = state_d == S_DONE;
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign bus.in_ready   = in_ready_q;
    assign bus.win_data   = win_q;
    assign bus.conv_start = conv_start_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = out_data_q;
endmodule

// File: tb/tb_conv_pool_sequencer.sv
// Directed bench: default layer (100 samples, K=5, POOL=5) plus a small K=3/POOL=3 layer.
module tb_conv_pool_sequencer;
    localparam int unsigned CH  = 8;
    localparam int unsigned DW  = 8;
    localparam int unsigned K   = 5;
    localparam int unsigned VW  = CH * DW;
    localparam int unsigned SCH = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1, start = 1'b0, busy, done;
    logic s_start = 1'b0, s_busy, s_done;
    int   checks = 0, errors = 0;

    conv_pool_sequencer_if #(.CH(CH), .DW(DW), .K(K)) bus ();
    conv_pool_sequencer_if #(.CH(SCH), .DW(DW), .K(3)) sbus ();

    conv_pool_sequencer #(.CH(CH), .DW(DW), .K(K), .POOL(5), .IN_LEN(100), .PAD(4)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .bus(bus));
    conv_pool_sequencer #(.CH(SCH), .DW(DW), .K(3), .POOL(3), .IN_LEN(10), .PAD(0)) u_small (
        .clk(clk), .rst(rst), .start(s_start), .busy(s_busy), .done(s_done), .bus(sbus));

    logic          m_valid = 1'b0, m_pend = 1'b0, inj_valid = 1'b0, neg_mode = 1'b0;
    logic [VW-1:0] m_data = '0, m_pend_data = '0, inj_data = '0;
    int            cs_count = 0;
    logic [VW-1:0] got[$];
    int            dones = 0;

    assign bus.conv_valid = m_valid | inj_valid;
    assign bus.conv_data  = inj_valid ? inj_data : m_data;

    logic                s_valid = 1'b0, s_pend = 1'b0;
    logic [SCH*DW-1:0]   s_data = '0, s_pend_data = '0;
    int                  s_cs = 0;
    assign sbus.conv_valid = s_valid;
    assign sbus.conv_data  = s_data;

    function automatic logic [DW-1:0] samp(input int n);
        return (n < 100) ? DW'(n - 50) : '0;
    endfunction

    function automatic logic [DW-1:0] exp_out(input int j);
        if (j == 19) return DW'(49);
        return (5 * j > 42) ? DW'(5 * j - 42) : '0;
    endfunction

    // Conv model: returns tap 0 one cycle after conv_start; also checks the window contents.
    always @(negedge clk) begin
        logic [CH*K*DW-1:0] expw;
        m_valid = m_pend;
        m_data  = m_pend_data;
        m_pend  = bus.conv_start;
        for (int c = 0; c < CH; c++)
            m_pend_data[c*DW +: DW] = neg_mode ? 8'h80 : bus.win_data[c*K*DW +: DW];
        if (bus.conv_start) begin
            for (int c = 0; c < CH; c++)
                for (int t = 0; t < K; t++)
                    expw[(c*K+t)*DW +: DW] = samp(cs_count + K - 1 - t);
            checks++;
            if (bus.win_data !== expw) begin
                errors++;
                $display("FAIL window conv=%0d got=%h exp=%h", cs_count, bus.win_data, expw);
            end
            cs_count++;
        end
    end

    always @(negedge clk) begin
        s_valid = s_pend;
        s_data  = s_pend_data;
        s_pend  = sbus.conv_start;
        for (int c = 0; c < SCH; c++)
            s_pend_data[c*DW +: DW] = sbus.win_data[c*3*DW +: DW];
        if (sbus.conv_start) s_cs++;
    end

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0)           begin errors++; $display("FAIL rst_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0)           begin errors++; $display("FAIL rst_done got=%b exp=0", done); end
        checks++; if (bus.in_ready !== 1'b0)   begin errors++; $display("FAIL rst_in_ready got=%b exp=0", bus.in_ready); end
        checks++; if (bus.conv_start !== 1'b0) begin errors++; $display("FAIL rst_conv_start got=%b exp=0", bus.conv_start); end
        checks++; if (bus.out_valid !== 1'b0)  begin errors++; $display("FAIL rst_out_valid got=%b exp=0", bus.out_valid); end
        checks++; if (bus.out_data !== '0)     begin errors++; $display("FAIL rst_out_data got=%h exp=0", bus.out_data); end
        checks++; if (bus.win_data !== '0)     begin errors++; $display("FAIL rst_win_data got=%h exp=0", bus.win_data); end
        checks++; if (s_busy !== 1'b0)         begin errors++; $display("FAIL rst_small_busy got=%b exp=0", s_busy); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_frame(input string name, input bit gaps, input int stall_at,
                              input bit poke, input bit neg);
        int fn, fcyc, ccyc;
        bit fhs, stalled, poked;
        logic [VW-1:0] held, expv;
        got.delete();
        dones = 0; stalled = 0; poked = 0; neg_mode = neg;
        if (poke) begin
            @(negedge clk); inj_valid = 1'b1; inj_data = {CH{8'd100}};
            @(negedge clk); inj_valid = 1'b0;
            checks++;
            if (busy !== 1'b0 || bus.out_valid !== 1'b0) begin
                errors++; $display("FAIL %s idle_conv_valid busy=%b out_valid=%b exp=0/0", name, busy, bus.out_valid);
            end
        end
        @(negedge clk); cs_count = 0; start = 1'b1;
        @(negedge clk); start = 1'b0;
        fork
            begin
                fn = 0; fcyc = 0;
                while (fn < 100 && fcyc < 3000) begin
                    bus.in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
                    bus.in_data  = {CH{samp(fn)}};
                    fhs = bus.in_valid && bus.in_ready;
                    @(negedge clk); fcyc++;
                    if (fhs) fn++;
                end
                bus.in_valid = 1'b0;
                checks++; if (fn != 100) begin errors++; $display("FAIL %s in_handshakes got=%0d exp=100", name, fn); end
            end
            begin
                ccyc = 0; bus.out_ready = 1'b1;
                while (busy && ccyc < 5000) begin
                    if (done) dones++;
                    if (poke && !poked && got.size() == 2 && bus.out_valid) begin
                        bus.out_ready = 1'b0; inj_valid = 1'b1; inj_data = {CH{8'd100}}; poked = 1;
                        @(negedge clk); ccyc++;
                        inj_valid = 1'b0; bus.out_ready = 1'b1;
                    end else if (stall_at >= 0 && !stalled && got.size() == stall_at && bus.out_valid) begin
                        held = bus.out_data; bus.out_ready = 1'b0; stalled = 1;
                        repeat (10) begin
                            @(negedge clk); ccyc++;
                            checks++;
                            if (bus.out_data !== held || bus.out_valid !== 1'b1 || bus.conv_start !== 1'b0) begin
                                errors++;
                                $display("FAIL %s stall data=%h exp=%h valid=%b conv_start=%b", name, bus.out_data, held, bus.out_valid, bus.conv_start);
                            end
                        end
                        bus.out_ready = 1'b1;
                    end else begin
                        if (bus.out_valid && bus.out_ready) got.push_back(bus.out_data);
                        @(negedge clk); ccyc++;
                    end
                end
                checks++; if (busy !== 1'b0) begin errors++; $display("FAIL %s timeout busy=%b exp=0", name, busy); end
            end
            begin
                if (poke) begin
                    repeat (40) @(negedge clk);
                    start = 1'b1;
                    @(negedge clk); start = 1'b0;
                end
            end
        join
        checks++; if (got.size() != 20) begin errors++; $display("FAIL %s out_count got=%0d exp=20", name, got.size()); end
        for (int j = 0; j < 20; j++) begin
            expv = neg ? '0 : {CH{exp_out(j)}};
            checks++;
            if (j >= got.size() || got[j] !== expv) begin
                errors++;
                $display("FAIL %s out%0d got=%h exp=%h", name, j, (j < got.size()) ? got[j] : '0, expv);
            end
        end
        checks++; if (dones != 1)      begin errors++; $display("FAIL %s done_pulses got=%0d exp=1", name, dones); end
        checks++; if (cs_count != 100) begin errors++; $display("FAIL %s conv_starts got=%0d exp=100", name, cs_count); end
        neg_mode = 1'b0;
    endtask

    task automatic test_reset_mid();
        int fn, fcyc, sd;
        bit fhs;
        @(negedge clk); cs_count = 0; start = 1'b1;
        @(negedge clk); start = 1'b0;
        bus.out_ready = 1'b1; fn = 0; fcyc = 0;
        while (fn < 37 && fcyc < 1000) begin
            bus.in_valid = 1'b1;
            bus.in_data  = {CH{samp(fn)}};
            fhs = bus.in_valid && bus.in_ready;
            @(negedge clk); fcyc++;
            if (fhs) fn++;
        end
        rst = 1'b1; bus.in_valid = 1'b0;
        @(negedge clk);
        checks++; if (bus.in_ready !== 1'b0)  begin errors++; $display("FAIL midrst_in_ready got=%b exp=0", bus.in_ready); end
        checks++; if (busy !== 1'b0)          begin errors++; $display("FAIL midrst_busy got=%b exp=0", busy); end
        checks++; if (bus.win_data !== '0)    begin errors++; $display("FAIL midrst_win got=%h exp=0", bus.win_data); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid got=%b exp=0", bus.out_valid); end
        rst = 1'b0; sd = 0;
        repeat (20) begin @(negedge clk); if (done) sd++; end
        checks++; if (sd != 0)        begin errors++; $display("FAIL midrst_done got=%0d exp=0", sd); end
        checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL midrst_idle busy=%b exp=0", busy); end
    endtask

    task automatic test_small();
        int fn, fcyc, ccyc, sd;
        bit fhs;
        logic [SCH*DW-1:0] sgot[$];
        logic [SCH*DW-1:0] e0, e1;
        e0 = {8'd18, 8'd4};
        e1 = {8'd15, 8'd7};
        sd = 0;
        @(negedge clk); s_cs = 0; s_start = 1'b1;
        @(negedge clk); s_start = 1'b0;
        fork
            begin
                fn = 0; fcyc = 0;
                while (fn < 10 && fcyc < 500) begin
                    sbus.in_valid = 1'b1;
                    sbus.in_data  = {DW'(20 - fn), DW'(fn)};
                    fhs = sbus.in_valid && sbus.in_ready;
                    @(negedge clk); fcyc++;
                    if (fhs) fn++;
                end
                sbus.in_valid = 1'b0;
            end
            begin
                ccyc = 0; sbus.out_ready = 1'b1;
                while (s_busy && ccyc < 1000) begin
                    if (s_done) sd++;
                    if (sbus.out_valid) sgot.push_back(sbus.out_data);
                    @(negedge clk); ccyc++;
                end
            end
        join
        checks++; if (fn != 10)          begin errors++; $display("FAIL small_in_handshakes got=%0d exp=10", fn); end
        checks++; if (s_cs != 8)         begin errors++; $display("FAIL small_conv_starts got=%0d exp=8", s_cs); end
        checks++; if (sgot.size() != 2)  begin errors++; $display("FAIL small_out_count got=%0d exp=2", sgot.size()); end
        checks++; if (sgot.size() < 1 || sgot[0] !== e0) begin errors++; $display("FAIL small_out0 got=%h exp=%h", (sgot.size() > 0) ? sgot[0] : '0, e0); end
        checks++; if (sgot.size() < 2 || sgot[1] !== e1) begin errors++; $display("FAIL small_out1 got=%h exp=%h", (sgot.size() > 1) ? sgot[1] : '0, e1); end
        checks++; if (sd != 1)           begin errors++; $display("FAIL small_done got=%0d exp=1", sd); end
        checks++; if (s_busy !== 1'b0)   begin errors++; $display("FAIL small_timeout busy=%b exp=0", s_busy); end
    endtask

    initial begin
        bus.in_valid  = 1'b0; bus.in_data  = '0; bus.out_ready  = 1'b0;
        sbus.in_valid = 1'b0; sbus.in_data = '0; sbus.out_ready = 1'b0;
        test_reset();
        test_frame("basic",    1'b0, -1, 1'b0, 1'b0);
        test_frame("stall",    1'b1,  3, 1'b0, 1'b0);
        test_frame("relu_neg", 1'b0, -1, 1'b0, 1'b1);
        test_reset_mid();
        test_frame("restart",  1'b0, -1, 1'b0, 1'b0);
        test_frame("ignored",  1'b0, -1, 1'b1, 1'b0);
        test_small();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
